uart_cmd_rcv: RTL and testbench

- UART receiver for the command link (8N1, LSB first).
- Recovers bytes from the serial line, presents them through a rdy/clr_rdy handshake, and decodes the two control commands 'G' (8'h47, go) and 'S' (8'h53, stop) into single-cycle pulses.
- Sits at the RX pin, downstream of the host/BLE-side UART transmitter, and feeds the power-up/auth logic.

---
 rtl/uart_cmd_rcv_if.sv | 23 ++
 rtl/uart_cmd_rcv.sv | 166 ++++++++++++++++
 tb/tb_uart_cmd_rcv.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_rcv_if.sv
// Command-link UART receiver bus: serial input, consumer handshake and
// decoded command pulses. The receiver uses the slave view, the consumer
// (or a testbench) drives through the master view.
interface uart_cmd_rcv_if;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       go;
  logic       stop;
  logic       frame_err;
  logic       overrun;

  modport master (
    output RX, clr_rdy,
    input  rx_data, rdy, go, stop, frame_err, overrun
  );

  modport slave (
    input  RX, clr_rdy,
    output rx_data, rdy, go, stop, frame_err, overrun
  );
endinterface

// File: rtl/uart_cmd_rcv.sv
// uart_cmd_rcv: 8N1 LSB-first UART receiver for the command link.
// Recovers bytes from RX, holds them behind a rdy/clr_rdy handshake and
// turns the GO_CODE / STOP_CODE bytes into single-cycle go / stop pulses.
// Optional build macro UART_RCV_OVERRUN_EN enables the sticky overrun flag;
// without it the overrun output is tied low.
// BAUD_DIV must be even and at least 16.
module uart_cmd_rcv #(
  parameter int         BAUD_DIV  = 2604,
  parameter logic [7:0] GO_CODE   = 8'h47,
  parameter logic [7:0] STOP_CODE = 8'h53
) (
  input logic           clk,
  input logic           rst,
  uart_cmd_rcv_if.slave bus
);

  // The counter reaches zero on the last clock of an interval, so loading
  // N-1 makes each interval exactly N clocks long.
  localparam int CNT_W = ($clog2(BAUD_DIV + 1) > 12) ? $clog2(BAUD_DIV + 1) : 12;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t           state, nxt_state;
  logic             rx_meta, rxs;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             sample;
  logic             load_half, load_full, start_ok, shift_en, frame_good, frame_bad;
  logic [7:0]       rx_data_q;
  logic             rdy_q, go_q, stop_q, ferr_q;

  assign sample = (baud_cnt == '0);

  // Two-flop synchroniser for the asynchronous RX pin, preset to the idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.RX;
      rxs     <= rx_meta;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  // Frame sequencing: start check at half a bit, 8 data samples, stop sample.
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:      if (!rxs) nxt_state = START;
      START:     if (sample) nxt_state = rxs ? IDLE : DATA;
      DATA:      if (sample && bit_cnt == 4'd7) nxt_state = STOP;
      STOP:      if (sample) nxt_state = rxs ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rxs) nxt_state = IDLE;
      default:   nxt_state = IDLE;
    endcase
  end

  // Per-state datapath strobes.
  always_comb begin
    load_half  = 1'b0;
    load_full  = 1'b0;
    start_ok   = 1'b0;
    shift_en   = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE:  load_half = !rxs;
      START: if (sample && !rxs) begin
               start_ok  = 1'b1;
               load_full = 1'b1;
             end
      DATA:  if (sample) begin
               shift_en  = 1'b1;
               load_full = 1'b1;
             end
      STOP:  if (sample) begin
               frame_good = rxs;
               frame_bad  = !rxs;
             end
      default: ;
    endcase
  end

  // Baud counter: loads on start edge and after each sample, then counts down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               baud_cnt <= '0;
    else if (load_half)    baud_cnt <= HALF_LOAD;
    else if (load_full)    baud_cnt <= FULL_LOAD;
    else if (baud_cnt != '0) baud_cnt <= baud_cnt - CNT_W'(1);
  end

  // Data bits arrive LSB first, so each new bit enters at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= 4'd0;
      shift_reg <= 8'h00;
    end else if (start_ok) begin
      bit_cnt   <= 4'd0;
    end else if (shift_en) begin
      bit_cnt   <= bit_cnt + 4'd1;
      shift_reg <= {rxs, shift_reg[7:1]};
    end
  end

  // Result registers; rdy drops only once a start bit is confirmed so a
  // rejected glitch leaves the handshake untouched, and a new byte beats clr_rdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_q <= 8'h00;
      rdy_q     <= 1'b0;
      go_q      <= 1'b0;
      stop_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      go_q   <= frame_good && (shift_reg == GO_CODE);
      stop_q <= frame_good && (shift_reg == STOP_CODE) && (shift_reg != GO_CODE);
      ferr_q <= frame_bad;
      if (frame_good) begin
        rx_data_q <= shift_reg;
        rdy_q     <= 1'b1;
      end else if (bus.clr_rdy || start_ok) begin
        rdy_q     <= 1'b0;
      end
    end
  end

`ifdef UART_RCV_OVERRUN_EN
  logic unread_q, overrun_q;

  // rdy already drops at the next start bit, so a separate flag remembers
  // whether the previous byte was ever acknowledged by clr_rdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unread_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else if (frame_good) begin
      unread_q <= 1'b1;
      if (bus.clr_rdy)   overrun_q <= 1'b0;
      else if (unread_q) overrun_q <= 1'b1;
    end else if (bus.clr_rdy) begin
      unread_q  <= 1'b0;
      overrun_q <= 1'b0;
    end
  end

  assign bus.overrun = overrun_q;
`else
  assign bus.overrun = 1'b0;
`endif

  assign bus.rx_data   = rx_data_q;
  assign bus.rdy       = rdy_q;
  assign bus.go        = go_q;
  assign bus.stop      = stop_q;
  assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Testbench for uart_cmd_rcv: a fast instance (BAUD_DIV = 20) driven by
// directed and random frames against a timed event model, plus a default
// instance (BAUD_DIV = 2604) checked for absolute frame latency.
module tb_uart_cmd_rcv;
  localparam int D     = 20;
  localparam int H     = D / 2;
  localparam int BIG_D = 2604;
`ifdef UART_RCV_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_big = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_rcv_if bus ();
  uart_cmd_rcv_if big_bus ();

  uart_cmd_rcv #(.BAUD_DIV(D), .GO_CODE(8'h47), .STOP_CODE(8'h53)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  uart_cmd_rcv dut_big (.clk(clk), .rst(rst_big), .bus(big_bus.slave));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model: the expected outputs, driven by events scheduled by the stimulus
  logic [7:0] m_data;
  logic       m_rdy, m_go, m_stop, m_ferr, m_ovr, m_unread;
  logic [7:0] ev_done [int];
  bit         ev_start [int];
  bit         ev_ferr [int];
  bit         force_clr [int];
  bit         rand_clr = 1'b0;
  bit         big_done = 1'b0;

  // Observations of the fast DUT for the directed pins
  int   rise_cyc = -1, last_go_cyc = -1, go_cnt = 0, stop_cnt = 0, ferr_cnt = 0;
  logic prev_rdy = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic clearObs();
    rise_cyc = -1; last_go_cyc = -1; go_cnt = 0; stop_cnt = 0; ferr_cnt = 0;
  endtask

  // Drive one frame starting at the current negedge. Confirmed start is
  // scheduled 2 + H clocks after the first capturing edge, the stop sample
  // 9*D later. abort_bit >= 0 asserts rst in the middle of that data bit.
  task automatic applyStimulus(input logic [7:0] b, input bit good_stop, input int extra_low,
                               input int abort_bit, input bit clr_at_done, output int c);
    int done_c;
    c = cyc;
    done_c = c + 3 + H + 9 * D;
    ev_start[c + 3 + H] = 1'b1;
    if (abort_bit < 0) begin
      if (good_stop) ev_done[done_c] = b;
      else           ev_ferr[done_c] = 1'b1;
      if (clr_at_done) force_clr[done_c] = 1'b1;
    end
    bus.RX = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      if (i == abort_bit) begin
        repeat (H) @(negedge clk);
        rst = 1'b1;
        bus.RX = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        return;
      end
      repeat (D) @(negedge clk);
    end
    bus.RX = good_stop;
    repeat (D) @(negedge clk);
    if (!good_stop) begin
      repeat (extra_low) @(negedge clk);
      bus.RX = 1'b1;
      repeat (D) @(negedge clk);
    end
  endtask

  task automatic applyGlitch(input int len);
    bus.RX = 1'b0;
    repeat (len) @(negedge clk);
    bus.RX = 1'b1;
    repeat (2 * D) @(negedge clk);
  endtask

  task automatic pulseClr();
    force_clr[cyc + 3] = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Model update at every edge, then per-cycle comparison of all outputs
  initial begin : compare_proc
    logic       clr_s, rst_s, prev_unread;
    logic [7:0] b;
    m_data = 8'h00; m_rdy = 0; m_go = 0; m_stop = 0; m_ferr = 0; m_ovr = 0; m_unread = 0;
    forever begin
      @(posedge clk);
      cyc++;
      clr_s = bus.clr_rdy;
      rst_s = rst;
      m_go = 0; m_stop = 0; m_ferr = 0;
      if (rst_s) begin
        m_data = 8'h00; m_rdy = 0; m_ovr = 0; m_unread = 0;
        ev_done.delete(); ev_start.delete(); ev_ferr.delete();
      end else begin
        prev_unread = m_unread;
        if (clr_s) begin m_rdy = 0; m_ovr = 0; m_unread = 0; end
        if (ev_start.exists(cyc)) m_rdy = 0;
        if (ev_done.exists(cyc)) begin
          b = ev_done[cyc];
          if (OVR_EN && prev_unread && !clr_s) m_ovr = 1;
          m_data = b; m_rdy = 1; m_unread = 1;
          m_go   = (b == 8'h47);
          m_stop = (b == 8'h53);
        end
        if (ev_ferr.exists(cyc)) m_ferr = 1;
      end
      #1;
      checkOutput($sformatf("outputs@%0d", cyc),
                  {19'd0, bus.rdy, bus.go, bus.stop, bus.frame_err, bus.overrun, bus.rx_data},
                  {19'd0, m_rdy, m_go, m_stop, m_ferr, m_ovr, m_data});
      if (bus.rdy && !prev_rdy) rise_cyc = cyc;
      prev_rdy = bus.rdy;
      if (bus.go) begin go_cnt++; last_go_cyc = cyc; end
      if (bus.stop) stop_cnt++;
      if (bus.frame_err) ferr_cnt++;
    end
  end

  // Consumer acknowledge: scheduled pulses plus optional random ones
  initial begin : clr_drive
    bus.clr_rdy = 1'b0;
    forever begin
      @(negedge clk);
      bus.clr_rdy = (rand_clr && ($urandom_range(7) == 0)) || force_clr.exists(cyc + 1);
    end
  end

  // Default-rate instance: one 'G' frame, absolute latency 24740 clocks
  initial begin : big_seq
    int c, rise, gcyc, gcnt, scnt;
    logic [7:0] b;
    b = 8'h47; rise = -1; gcyc = -1; gcnt = 0; scnt = 0;
    big_bus.RX = 1'b1;
    big_bus.clr_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst_big = 1'b0;
    repeat (3) @(negedge clk);
    c = cyc;
    fork
      begin
        big_bus.RX = 1'b0;
        repeat (BIG_D) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          big_bus.RX = b[i];
          repeat (BIG_D) @(negedge clk);
        end
        big_bus.RX = 1'b1;
        repeat (BIG_D) @(negedge clk);
      end
      begin
        repeat (11 * BIG_D) begin
          @(posedge clk);
          #1;
          if (big_bus.rdy && rise < 0) rise = cyc;
          if (big_bus.go) begin gcnt++; gcyc = cyc; end
          if (big_bus.stop) scnt++;
        end
      end
    join
    checkOutput("big rdy latency", rise - (c + 1), 24740);
    checkOutput("big go latency", gcyc - (c + 1), 24740);
    checkOutput("big go count", gcnt, 1);
    checkOutput("big stop count", scnt, 0);
    checkOutput("big rx_data", big_bus.rx_data, 8'h47);
    big_done = 1'b1;
  end

  initial begin : main_seq
    int c, gap, extra;
    logic [7:0] b;
    bit good;
    bus.RX = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset rx_data", bus.rx_data, 8'h00);
    checkOutput("reset flags", {bus.rdy, bus.go, bus.stop, bus.frame_err, bus.overrun}, 5'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] single G frame");
    clearObs();
    applyStimulus(8'h47, 1, 0, -1, 0, c);
    checkOutput("G rdy latency", rise_cyc - (c + 1), 192);
    checkOutput("G go latency", last_go_cyc - (c + 1), 192);
    checkOutput("G go count", go_cnt, 1);
    checkOutput("G stop count", stop_cnt, 0);
    checkOutput("G rx_data", bus.rx_data, 8'h47);
    pulseClr();
    checkOutput("clr rdy", bus.rdy, 0);

    $display("[TB] S then A5 back-to-back");
    clearObs();
    applyStimulus(8'h53, 1, 0, -1, 0, c);
    applyStimulus(8'hA5, 1, 0, -1, 0, c);
    checkOutput("b2b stop count", stop_cnt, 1);
    checkOutput("b2b go count", go_cnt, 0);
    checkOutput("b2b rx_data", bus.rx_data, 8'hA5);
    checkOutput("b2b overrun", bus.overrun, OVR_EN);

    $display("[TB] start-bit glitch");
    clearObs();
    applyGlitch(H - 2);
    checkOutput("glitch rdy", bus.rdy, 1);
    checkOutput("glitch rx_data", bus.rx_data, 8'hA5);
    checkOutput("glitch pulses", go_cnt + stop_cnt + ferr_cnt, 0);
    applyStimulus(8'h47, 1, 0, -1, 0, c);
    checkOutput("post-glitch rx_data", bus.rx_data, 8'h47);
    checkOutput("post-glitch go count", go_cnt, 1);
    pulseClr();

    $display("[TB] framing error with break");
    clearObs();
    applyStimulus(8'h47, 0, 5 * D, -1, 0, c);
    checkOutput("ferr count", ferr_cnt, 1);
    checkOutput("ferr go count", go_cnt, 0);
    checkOutput("ferr rdy", bus.rdy, 0);
    checkOutput("ferr rx_data", bus.rx_data, 8'h47);

    $display("[TB] set wins over clr_rdy");
    applyStimulus(8'h11, 1, 0, -1, 0, c);
    applyStimulus(8'h22, 1, 0, -1, 0, c);
    checkOutput("pre-setwins overrun", bus.overrun, OVR_EN);
    applyStimulus(8'h33, 1, 0, -1, 1, c);
    checkOutput("setwins rdy", bus.rdy, 1);
    checkOutput("setwins overrun", bus.overrun, 0);
    checkOutput("setwins rx_data", bus.rx_data, 8'h33);
    pulseClr();
    checkOutput("late clr rdy", bus.rdy, 0);

    $display("[TB] reset mid-frame");
    clearObs();
    applyStimulus(8'h3C, 1, 0, 4, 0, c);
    checkOutput("abort rx_data", bus.rx_data, 8'h00);
    checkOutput("abort flags", {bus.rdy, bus.go, bus.stop, bus.frame_err, bus.overrun}, 5'b0);
    repeat (2 * D) @(negedge clk);
    applyStimulus(8'h53, 1, 0, -1, 0, c);
    checkOutput("after abort stop count", stop_cnt, 1);
    checkOutput("after abort go count", go_cnt, 0);
    checkOutput("after abort rdy", bus.rdy, 1);
    checkOutput("after abort rx_data", bus.rx_data, 8'h53);

    $display("[TB] random frames");
    rand_clr = 1'b1;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(3))
        0:       b = 8'h47;
        1:       b = 8'h53;
        default: b = 8'($urandom_range(255));
      endcase
      good  = ($urandom_range(9) != 0);
      extra = good ? 0 : int'($urandom_range(2 * D));
      gap   = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(2 * D));
      applyStimulus(b, good, extra, -1, 0, c);
      repeat (gap) @(negedge clk);
    end
    rand_clr = 1'b0;
    repeat (2 * D) @(negedge clk);

    for (int i = 0; i < 40000 && !big_done; i++) @(negedge clk);
    checkOutput("big instance finished", big_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
